sv32_page_walker: RTL and testbench
===================================

Name: sv32_page_walker

Overview:
- Responder on the TLB-miss channel: accepts a miss address from an I-/D-TLB and walks the Sv32 two-level page table in memory using the root PPN in SATP.
- Returns the leaf PTE, or a fault indication, on the TLB refill port (DATA_FROM_AXIM side of the TLB).
- Sits between the TLB refill interface and the AXI master read channel.

Parameters:
- DATA_WIDTH, 32, PTE / memory read data width.
- ADDR_WIDTH, 32, virtual address width and memory read address width (physical address bits above ADDR_WIDTH are discarded).
- PTESIZE, 4, bytes per PTE (index shift = log2(PTESIZE)).
- PAGE_OFFSET_WIDTH, 12, page offset bits.
- VPN_LEN, 10, bits per VPN level.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- FLUSH  in  1  abort the walk in progress (TLB flush / SATP write)
- SATP  in  64  [31] mode (1 = Sv32, 0 = bare), [21:0] root PPN; other bits ignored
- REQ_VALID  in  1  miss request from TLB (single-cycle pulse)
- REQ_VADDR  in  ADDR_WIDTH  missing virtual address
- RESP_VALID  out  1  one-cycle pulse, response valid
- RESP_DATA  out  DATA_WIDTH  leaf PTE with PPN[31:10] usable as-is; 0 on fault
- RESP_FAULT  out  1  page fault, qualified by RESP_VALID
- MEM_RD_VALID  out  1  memory read request
- MEM_RD_ADDR  out  ADDR_WIDTH  PTE physical address
- MEM_RD_READY  in  1  memory accepts request
- MEM_RD_DATA_VALID  in  1  read data valid (one pulse per accepted request)
- MEM_RD_DATA  in  DATA_WIDTH  read data
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Clock and reset: all state changes on posedge CLK. RST wins over every other input.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DRAIN.
- IDLE:
  - On REQ_VALID, latch REQ_VADDR and SATP.
  - If SATP[31] = 0, go to RESP with the identity PTE {2'b00, vaddr[31:12], 10'h00F}, no fault.
  - Otherwise go to L1_REQ.
  - REQ_VALID in any other state is ignored; the TLB never re-requests while a walk is outstanding.
- L1_REQ:
  - MEM_RD_VALID = 1.
  - MEM_RD_ADDR = (root_ppn << 12) + vpn1*PTESIZE, where vpn1 = vaddr[31:22].
  - Address is held stable until MEM_RD_READY. On handshake, go to L1_WAIT.
- L1_WAIT, on MEM_RD_DATA_VALID (PTE bits: V=0, R=1, W=2, X=3):
  - V=0, or R=0 with W=1: fault, go to RESP.
  - R|X = 1 (megapage leaf):
    - PTE[19:10] != 0: misaligned, fault.
    - Otherwise respond with {PTE[31:20], vaddr[31:22]... specifically vpn0 = vaddr[21:12], PTE[9:0]}; go to RESP.
  - Otherwise (pointer): next base = PTE[31:10] << 12; go to L0_REQ.
- L0_REQ:
  - Same handshake as L1_REQ.
  - MEM_RD_ADDR = next base + vpn0*PTESIZE.
- L0_WAIT:
  - Invalid PTE as in L1_WAIT: fault.
  - Non-leaf PTE: fault.
  - Leaf PTE: respond with the PTE unchanged.
- RESP:
  - RESP_VALID = 1 for exactly one cycle, with RESP_DATA and RESP_FAULT registered.
  - Then go to IDLE. A new request can be accepted in the cycle after RESP.
- Fault response: RESP_DATA = 0, RESP_FAULT = 1.
- Latency with zero-wait memory (READY = 1, data one cycle after handshake), REQ at edge T:
  - Bare mode: RESP_VALID during cycle T+1.
  - 2-level walk: RESP_VALID during cycle T+5.
- Address arithmetic: computed in 34 bits, truncated to ADDR_WIDTH. No carry checks.
- FLUSH behaviour:
  - In L1_REQ, L0_REQ or RESP: go to IDLE next cycle; no RESP_VALID.
  - In L1_WAIT or L0_WAIT: go to DRAIN, which discards exactly one MEM_RD_DATA_VALID and then returns to IDLE.
  - FLUSH and MEM_RD_DATA_VALID in the same cycle in a WAIT state: the data is discarded and the next state is IDLE.
  - FLUSH in IDLE: no effect. A REQ_VALID in the same cycle is dropped.
- Reset mid-walk: immediate return to IDLE. The memory side is reset by the same RST.

Test Plan:
- Two-level walk:
  - Stimulus: SATP = 0x8000_0400, REQ_VADDR = 0x1234_5678, READY = 1.
  - Required: first read at 0x0040_0120. Return 0x0010_0401 → second read at 0x0040_1D14. Return 0x2000_00CF → RESP_VALID once, RESP_DATA = 0x2000_00CF, FAULT = 0, at T+5.
- Megapage:
  - Stimulus: same request; first read returns 0x2000_00CF.
  - Required: no second read; RESP_DATA = 0x200D_14CF, FAULT = 0.
- Faults:
  - L1 read returns 0x0000_0000 → RESP_FAULT = 1, RESP_DATA = 0, only one read issued.
  - L1 read returns 0x2000_04CF (misaligned megapage) → fault.
  - L0 read returns 0x0010_0401 (non-leaf at level 0) → fault.
- Bare mode:
  - Stimulus: SATP = 0, REQ_VADDR = 0x8000_1ABC.
  - Required: no MEM_RD_VALID; RESP_DATA = 0x2000_040F at T+1.
- Backpressure:
  - Stimulus: MEM_RD_READY held low 5 cycles in L1_REQ.
  - Required: MEM_RD_VALID and MEM_RD_ADDR stable for all 5 cycles; single handshake; correct response afterwards.
- Flush:
  - FLUSH in L0_WAIT, data arrives 3 cycles later → no RESP_VALID, BUSY drops the cycle after the data. A following request walks correctly.
  - RST asserted mid-L1_WAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/sv32_page_walker.sv
// Sv32 hardware page-table walker: services I-/D-TLB misses by reading up to two PTEs
// from memory and returns the leaf PTE (or a fault) on the TLB refill port.
module sv32_page_walker #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned PTESIZE           = 4,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  parameter int unsigned VPN_LEN           = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic [63:0]           SATP,
  input  logic                  REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ_VADDR,
  output logic                  RESP_VALID,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic                  RESP_FAULT,
  output logic                  MEM_RD_VALID,
  output logic [ADDR_WIDTH-1:0] MEM_RD_ADDR,
  input  logic                  MEM_RD_READY,
  input  logic                  MEM_RD_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
  output logic                  BUSY
);

  localparam int unsigned PpnWidth    = 22;
  localparam int unsigned PaWidth     = PpnWidth + PAGE_OFFSET_WIDTH;
  localparam int unsigned PteShift    = $clog2(PTESIZE);
  localparam int unsigned PteFlagW    = 10;
  localparam int unsigned VpnWidth    = ADDR_WIDTH - PAGE_OFFSET_WIDTH;
  localparam int unsigned SatpModeBit = 31;

  typedef enum logic [2:0] {
    StIdle, StL1Req, StL1Wait, StL0Req, StL0Wait, StResp, StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [VpnWidth-1:0]   vpn_q, vpn_d;
  logic [PpnWidth-1:0]   root_ppn_q, root_ppn_d;
  logic [PaWidth-1:0]    base_q, base_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_fault_q, resp_fault_d;

  logic [VPN_LEN-1:0]    vpn1, vpn0;
  logic [PaWidth-1:0]    l1_addr, l0_addr, ptr_base;
  logic [DATA_WIDTH-1:0] mega_pte, bare_pte;
  logic                  pte_v, pte_r, pte_w, pte_x;
  logic                  pte_bad, pte_leaf, pte_misaligned;
  logic                  unused_bits;

  assign vpn1 = vpn_q[VpnWidth-1 -: VPN_LEN];
  assign vpn0 = vpn_q[VPN_LEN-1:0];

  // Address arithmetic is 34-bit physical; the upper bits are simply dropped on output.
  assign l1_addr  = PaWidth'({root_ppn_q, {PAGE_OFFSET_WIDTH{1'b0}}}) +
                    (PaWidth'(vpn1) << PteShift);
  assign l0_addr  = base_q + (PaWidth'(vpn0) << PteShift);
  assign ptr_base = PaWidth'({MEM_RD_DATA[DATA_WIDTH-1:PteFlagW], {PAGE_OFFSET_WIDTH{1'b0}}});

  assign pte_v          = MEM_RD_DATA[0];
  assign pte_r          = MEM_RD_DATA[1];
  assign pte_w          = MEM_RD_DATA[2];
  assign pte_x          = MEM_RD_DATA[3];
  assign pte_bad        = !pte_v || (!pte_r && pte_w);
  assign pte_leaf       = pte_r || pte_x;
  assign pte_misaligned = |MEM_RD_DATA[PteFlagW +: VPN_LEN];

  // Megapage: splice the VA's vpn0 into PPN0 so the TLB sees a 4 KiB-style PPN.
  assign mega_pte = {MEM_RD_DATA[DATA_WIDTH-1:PteFlagW+VPN_LEN], vpn0,
                     MEM_RD_DATA[PteFlagW-1:0]};
  assign bare_pte = DATA_WIDTH'({REQ_VADDR[ADDR_WIDTH-1:PAGE_OFFSET_WIDTH], PteFlagW'(4'hF)});

  assign unused_bits = ^{SATP[63:32], SATP[30:PpnWidth], REQ_VADDR[PAGE_OFFSET_WIDTH-1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      vpn_q        <= '0;
      root_ppn_q   <= '0;
      base_q       <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vpn_q        <= vpn_d;
      root_ppn_q   <= root_ppn_d;
      base_q       <= base_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vpn_d        = vpn_q;
    root_ppn_d   = root_ppn_q;
    base_d       = base_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      StIdle: begin
        if (REQ_VALID && !FLUSH) begin
          vpn_d      = REQ_VADDR[ADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
          root_ppn_d = SATP[PpnWidth-1:0];
          if (SATP[SatpModeBit]) begin
            state_d = StL1Req;
          end else begin
            resp_data_d  = bare_pte;
            resp_fault_d = 1'b0;
            state_d      = StResp;
          end
        end
      end
      StL1Req: begin
        if (FLUSH)             state_d = StIdle;
        else if (MEM_RD_READY) state_d = StL1Wait;
      end
      StL1Wait: begin
        if (FLUSH) begin
          // A read is still in flight unless it lands this very cycle.
          state_d = MEM_RD_DATA_VALID ? StIdle : StDrain;
        end else if (MEM_RD_DATA_VALID) begin
          state_d      = StResp;
          resp_data_d  = '0;
          resp_fault_d = 1'b1;
          if (!pte_bad && pte_leaf && !pte_misaligned) begin
            resp_data_d  = mega_pte;
            resp_fault_d = 1'b0;
          end else if (!pte_bad && !pte_leaf) begin
            base_d  = ptr_base;
            state_d = StL0Req;
          end
        end
      end
      StL0Req: begin
        if (FLUSH)             state_d = StIdle;
        else if (MEM_RD_READY) state_d = StL0Wait;
      end
      StL0Wait: begin
        if (FLUSH) begin
          state_d = MEM_RD_DATA_VALID ? StIdle : StDrain;
        end else if (MEM_RD_DATA_VALID) begin
          state_d      = StResp;
          resp_data_d  = '0;
          resp_fault_d = 1'b1;
          if (!pte_bad && pte_leaf) begin
            resp_data_d  = MEM_RD_DATA;
            resp_fault_d = 1'b0;
          end
        end
      end
      StResp:  state_d = StIdle;
      StDrain: if (MEM_RD_DATA_VALID) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    RESP_VALID   = 1'b0;
    RESP_DATA    = '0;
    RESP_FAULT   = 1'b0;
    MEM_RD_VALID = 1'b0;
    MEM_RD_ADDR  = '0;
    BUSY         = (state_q != StIdle);
    case (state_q)
      StL1Req: begin
        MEM_RD_VALID = 1'b1;
        MEM_RD_ADDR  = ADDR_WIDTH'(l1_addr);
      end
      StL0Req: begin
        MEM_RD_VALID = 1'b1;
        MEM_RD_ADDR  = ADDR_WIDTH'(l0_addr);
      end
      StResp: begin
        RESP_VALID = 1'b1;
        RESP_DATA  = resp_data_q;
        RESP_FAULT = resp_fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sv32_page_walker.sv
// Bench for sv32_page_walker: directed scenarios plus randomized walks against a
// table-lookup reference model, with a responsive memory model on the read channel.
module tb_sv32_page_walker;

  logic        CLK, RST, FLUSH, REQ_VALID;
  logic [63:0] SATP;
  logic [31:0] REQ_VADDR;
  logic        RESP_VALID, RESP_FAULT, MEM_RD_VALID, MEM_RD_READY, MEM_RD_DATA_VALID, BUSY;
  logic [31:0] RESP_DATA, MEM_RD_ADDR, MEM_RD_DATA;

  sv32_page_walker dut (
    .CLK               (CLK),
    .RST               (RST),
    .FLUSH             (FLUSH),
    .SATP              (SATP),
    .REQ_VALID         (REQ_VALID),
    .REQ_VADDR         (REQ_VADDR),
    .RESP_VALID        (RESP_VALID),
    .RESP_DATA         (RESP_DATA),
    .RESP_FAULT        (RESP_FAULT),
    .MEM_RD_VALID      (MEM_RD_VALID),
    .MEM_RD_ADDR       (MEM_RD_ADDR),
    .MEM_RD_READY      (MEM_RD_READY),
    .MEM_RD_DATA_VALID (MEM_RD_DATA_VALID),
    .MEM_RD_DATA       (MEM_RD_DATA),
    .BUSY              (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [31:0]];
  int          ncyc = 0, req_n = 0, dv_cnt = 0;
  int          stall_cnt = 0, stall_first = 0, stall_last = 0, bp_cycles = 0, mem_lat = 1;
  bit          mem_rand = 1'b0;
  logic [31:0] rd_log[$], stall_addr[$], resp_data_log[$], pend_data[$];
  bit          resp_fault_log[$];
  int          resp_cyc_log[$], pend_due[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] pte_addr(input logic [63:0] ppn, input logic [31:0] idx);
    return 32'(ppn * 64'd4096 + 64'(idx) * 64'd4);
  endfunction

  function automatic bit pte_ok(input logic [31:0] p);
    return p[0] && !(p[2] && !p[1]);
  endfunction

  function automatic bit pte_is_leaf(input logic [31:0] p);
    return p[1] || p[3];
  endfunction

  // Reference walk: straight from the Sv32 rules, reading the same table the memory serves.
  function automatic void ref_walk(input logic [31:0] va, input logic [63:0] satp,
                                   output logic [31:0] data, output bit fault,
                                   output int nreads, output logic [31:0] a0,
                                   output logic [31:0] a1);
    logic [31:0] pte, vpn1, vpn0;
    vpn1 = va >> 22;
    vpn0 = (va >> 12) & 32'h3FF;
    data = 0; fault = 0; nreads = 0; a0 = 0; a1 = 0;
    if (!satp[31]) begin
      data = ((va >> 12) << 10) | 32'hF;
      return;
    end
    a0 = pte_addr(satp & 64'h3F_FFFF, vpn1);
    nreads = 1;
    pte = mem_read(a0);
    if (!pte_ok(pte)) begin
      fault = 1;
    end else if (pte_is_leaf(pte)) begin
      if (((pte >> 10) & 32'h3FF) != 0) fault = 1;
      else data = (pte & 32'hFFF0_03FF) | (vpn0 << 10);
    end else begin
      a1 = pte_addr(64'(pte >> 10), vpn0);
      nreads = 2;
      pte = mem_read(a1);
      if (pte_ok(pte) && pte_is_leaf(pte)) data = pte;
      else fault = 1;
    end
  endfunction

  function automatic logic [31:0] make_pte(input int kind);
    logic [31:0] p;
    p = $urandom;
    case (kind)
      0: p[0] = 1'b0;
      1: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b1; end
      2: begin p[0] = 1'b1; p[1] = 1'b1; p[19:10] = 10'h0; end
      3: begin p[0] = 1'b1; p[3] = 1'b1; p[19:10] = 10'($urandom_range(1, 1023)); end
      5: begin p[0] = 1'b1; p[1] = 1'b1; end
      default: begin p[0] = 1'b1; p[3:1] = 3'b000; end
    endcase
    return p;
  endfunction

  // Memory responder and response monitor, both sampling on the falling edge.
  initial begin
    MEM_RD_READY      = 1'b0;
    MEM_RD_DATA_VALID = 1'b0;
    MEM_RD_DATA       = '0;
    forever begin
      @(negedge CLK);
      ncyc++;
      MEM_RD_DATA_VALID = 1'b0;
      if (RST) begin
        pend_due.delete();
        pend_data.delete();
        MEM_RD_READY = 1'b0;
      end else begin
        if (REQ_VALID && !BUSY) req_n = ncyc;
        if (RESP_VALID) begin
          resp_data_log.push_back(RESP_DATA);
          resp_fault_log.push_back(RESP_FAULT);
          resp_cyc_log.push_back(ncyc);
        end
        if (pend_due.size() > 0 && pend_due[0] == ncyc) begin
          MEM_RD_DATA_VALID = 1'b1;
          MEM_RD_DATA       = pend_data.pop_front();
          void'(pend_due.pop_front());
          dv_cnt++;
        end
        if (MEM_RD_VALID && bp_cycles > stall_cnt && rd_log.size() == 0) begin
          MEM_RD_READY = 1'b0;
          if (stall_cnt == 0) stall_first = ncyc;
          stall_last = ncyc;
          stall_cnt++;
          stall_addr.push_back(MEM_RD_ADDR);
        end else begin
          MEM_RD_READY = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (MEM_RD_VALID && MEM_RD_READY) begin
          rd_log.push_back(MEM_RD_ADDR);
          pend_due.push_back(ncyc + (mem_rand ? int'($urandom_range(1, 3)) : mem_lat));
          pend_data.push_back(mem_read(MEM_RD_ADDR));
        end
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    resp_data_log.delete();
    resp_fault_log.delete();
    resp_cyc_log.delete();
    stall_addr.delete();
    stall_cnt = 0;
  endtask

  task automatic issue(input logic [31:0] va, input logic [63:0] satp);
    @(posedge CLK); #1;
    REQ_VALID = 1'b1;
    REQ_VADDR = va;
    SATP      = satp;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},       BUSY, 0);
    check({tag, " resp_valid"}, RESP_VALID, 0);
    check({tag, " rd_valid"},   MEM_RD_VALID, 0);
    check({tag, " data_addr"},  {RESP_FAULT, RESP_DATA, MEM_RD_ADDR}, 0);
  endtask

  // exp_lat < 0 skips the latency check; latency is counted so a bare request gives 1.
  task automatic run_walk(input string tag, input logic [31:0] va, input logic [63:0] satp,
                          input logic [31:0] exp_data, input bit exp_fault, input int exp_nreads,
                          input logic [31:0] exp_a0, input logic [31:0] exp_a1, input int exp_lat);
    int waited;
    waited = 0;
    clear_logs();
    issue(va, satp);
    while (resp_data_log.size() == 0 && waited < 400) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (resp_data_log.size() == 0) begin
      check({tag, " resp_timeout"}, 0, 1);
      return;
    end
    repeat (4) @(posedge CLK);
    #1;
    check({tag, " resp_count"}, resp_data_log.size(), 1);
    check({tag, " data"},  resp_data_log[0], exp_data);
    check({tag, " fault"}, resp_fault_log[0], exp_fault);
    check({tag, " nreads"}, rd_log.size(), exp_nreads);
    if (exp_nreads > 0 && rd_log.size() > 0) check({tag, " addr0"}, rd_log[0], exp_a0);
    if (exp_nreads > 1 && rd_log.size() > 1) check({tag, " addr1"}, rd_log[1], exp_a1);
    if (exp_lat >= 0) check({tag, " latency"}, resp_cyc_log[0] - req_n, exp_lat);
  endtask

  logic [31:0] va, p1, p0, a0, a1, ed, ea0, ea1;
  logic [63:0] satp;
  bit          ef;
  int          en, k, k0, waited, dv_before;

  initial begin
    RST = 1'b1; FLUSH = 1'b0; REQ_VALID = 1'b0; REQ_VADDR = '0; SATP = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST = 1'b0;

    mem.delete();
    mem[32'h0040_0120] = 32'h0010_0401;
    mem[32'h0040_1D14] = 32'h2000_00CF;
    run_walk("walk2", 32'h1234_5678, 64'h8000_0400, 32'h2000_00CF, 0, 2,
             32'h0040_0120, 32'h0040_1D14, 5);

    mem[32'h0040_0120] = 32'h2000_00CF;
    run_walk("mega", 32'h1234_5678, 64'h8000_0400, 32'h200D_14CF, 0, 1, 32'h0040_0120, 0, -1);

    mem[32'h0040_0120] = 32'h0000_0000;
    run_walk("inv_l1", 32'h1234_5678, 64'h8000_0400, 0, 1, 1, 32'h0040_0120, 0, -1);

    mem[32'h0040_0120] = 32'h2000_04CF;
    run_walk("misalign", 32'h1234_5678, 64'h8000_0400, 0, 1, 1, 32'h0040_0120, 0, -1);

    mem[32'h0040_0120] = 32'h0010_0401;
    mem[32'h0040_1D14] = 32'h0010_0401;
    run_walk("nonleaf_l0", 32'h1234_5678, 64'h8000_0400, 0, 1, 2,
             32'h0040_0120, 32'h0040_1D14, -1);

    run_walk("bare", 32'h8000_1ABC, 64'h0, 32'h2000_040F, 0, 0, 0, 0, 1);

    mem[32'h0040_1D14] = 32'h2000_00CF;
    bp_cycles = 5;
    run_walk("bp", 32'h1234_5678, 64'h8000_0400, 32'h2000_00CF, 0, 2,
             32'h0040_0120, 32'h0040_1D14, -1);
    bp_cycles = 0;
    check("bp stall_cycles", stall_addr.size(), 5);
    check("bp stall_span", stall_last - stall_first, 4);
    foreach (stall_addr[i]) check($sformatf("bp stall_addr%0d", i), stall_addr[i], 32'h0040_0120);

    // FLUSH in IDLE drops a simultaneous request.
    clear_logs();
    @(posedge CLK); #1;
    FLUSH = 1'b1; REQ_VALID = 1'b1; REQ_VADDR = 32'h8000_1ABC; SATP = 64'h0;
    @(posedge CLK); #1;
    FLUSH = 1'b0; REQ_VALID = 1'b0;
    check("flush_idle busy", BUSY, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("flush_idle resp_count", resp_data_log.size(), 0);

    // FLUSH while the level-0 read is in flight; its data arrives three cycles later.
    clear_logs();
    mem_lat = 4;
    issue(32'h1234_5678, 64'h8000_0400);
    waited = 0;
    while (rd_log.size() < 2 && waited < 100) begin
      @(posedge CLK); #1;
      waited++;
    end
    check("flush_l0 reached", rd_log.size(), 2);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    dv_before = dv_cnt;
    check("flush_l0 busy_a", BUSY, 1);
    @(posedge CLK); #1;
    check("flush_l0 busy_b", BUSY, 1);
    @(posedge CLK); #1;
    check("flush_l0 busy_c", BUSY, 1);
    @(posedge CLK); #1;
    check("flush_l0 busy_after_data", BUSY, 0);
    check("flush_l0 data_seen", dv_cnt - dv_before, 1);
    check("flush_l0 no_resp", resp_data_log.size(), 0);
    mem_lat = 1;
    run_walk("post_flush", 32'h1234_5678, 64'h8000_0400, 32'h2000_00CF, 0, 2,
             32'h0040_0120, 32'h0040_1D14, 5);

    // Reset while waiting on the level-1 read.
    clear_logs();
    mem_lat = 4;
    issue(32'h1234_5678, 64'h8000_0400);
    waited = 0;
    while (rd_log.size() < 1 && waited < 100) begin
      @(posedge CLK); #1;
      waited++;
    end
    check("rst_mid reached", rd_log.size(), 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_all_zero("rst_mid");
    RST = 1'b0;
    mem_lat = 1;

    mem_rand = 1'b1;
    for (int it = 0; it < 60; it++) begin
      mem.delete();
      va = $urandom;
      satp = {$urandom, $urandom};
      satp[31] = ($urandom_range(0, 7) != 0);
      a0 = pte_addr(satp & 64'h3F_FFFF, va >> 22);
      k = $urandom_range(0, 7);
      p1 = make_pte(k >= 4 ? 4 : k);
      mem[a0] = p1;
      if (k >= 4) begin
        a1 = pte_addr(64'(p1 >> 10), (va >> 12) & 32'h3FF);
        k0 = $urandom_range(0, 4);
        p0 = make_pte(k0 == 2 ? 4 : (k0 >= 3 ? 5 : k0));
        mem[a1] = p0;
      end
      ref_walk(va, satp, ed, ef, en, ea0, ea1);
      run_walk($sformatf("rand%0d", it), va, satp, ed, ef, en, ea0, ea1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
